// File: rtl/jtcop_sdram_resp_pkg.sv
// Shared definitions for the memory-backed SDRAM responder: FSM encoding and memory timing.
package jtcop_sdram_resp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StData
    } state_e;

    // Cycles from mem_addr to valid mem_dout on the backing memory
    localparam int unsigned MemLat = 1;

endpackage

// File: rtl/jtcop_sdram_rr.sv
// 4-way round-robin arbiter: search starts at ptr and wraps; next_ptr is the bank after the winner.
module jtcop_sdram_rr (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic [1:0] next_ptr
);

    logic [1:0] cand;

    always_comb begin
        cand      = '0;
        gnt_idx   = ptr;
        gnt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt      = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
        next_ptr = gnt_idx + 2'd1;
    end

endmodule

// File: rtl/jtcop_sdram_resp.sv
// Four-bank SDRAM request responder backed by a synchronous word memory.
// One transaction in flight; strobes are decoded from the registered state and counter.
module jtcop_sdram_resp
    import jtcop_sdram_resp_pkg::*;
#(
    parameter int unsigned AW    = 24,
    parameter int unsigned LAT   = 3,
    parameter int unsigned BURST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [21:0]   ba0_addr,
    input  logic [21:0]   ba1_addr,
    input  logic [21:0]   ba2_addr,
    input  logic [21:0]   ba3_addr,
    input  logic [3:0]    ba_rd,
    input  logic          ba_wr,
    input  logic [15:0]   ba0_din,
    input  logic [1:0]    ba0_din_m,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_dst,
    output logic [3:0]    ba_dok,
    output logic [3:0]    ba_rdy,
    output logic [15:0]   data_read,
    input  logic          downloading,
    input  logic [21:0]   prog_addr,
    input  logic [1:0]    prog_ba,
    input  logic [15:0]   prog_data,
    input  logic [1:0]    prog_mask,
    input  logic          prog_we,
    input  logic          prog_rd,
    output logic          prog_ack,
    output logic          prog_rdy,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_we,
    input  logic [15:0]   mem_dout
);

    localparam logic [4:0] CntLat     = 5'(LAT);
    localparam logic [4:0] CntWaitEnd = 5'(LAT - 1);
    localparam logic [4:0] CntLast    = 5'(LAT + BURST - 1);
    localparam logic [4:0] CntFetch   = 5'(LAT - 1 - MemLat);
    localparam logic [4:0] CntCapHi   = 5'(LAT + BURST - 2);

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [1:0]      bank_q;
    logic [1:0]      ptr_q;
    logic            prog_q;
    logic            wr_q;
    logic [AW-1:0]   mem_addr_q;
    logic [15:0]     mem_din_q;
    logic [1:0]      we_mask_q;
    logic [15:0]     data_q;

    logic [3:0]      rr_req;
    logic [3:0]      rr_gnt;
    logic [1:0]      rr_idx;
    logic            rr_valid;
    logic [1:0]      rr_next;
    logic [21:0]     sel_addr;
    logic            prog_req;
    logic            done;
    logic            grant;
    logic            capture;
    logic [3:0]      bank_oh;

    assign rr_req   = {ba_rd[3:1], ba_rd[0] | ba_wr};
    assign prog_req = prog_we | prog_rd;

    jtcop_sdram_rr u_rr (
        .req       (rr_req),
        .ptr       (ptr_q),
        .gnt       (rr_gnt),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid),
        .next_ptr  (rr_next)
    );

    always_comb begin
        unique case (rr_idx)
            2'd0: sel_addr = ba0_addr;
            2'd1: sel_addr = ba1_addr;
            2'd2: sel_addr = ba2_addr;
            2'd3: sel_addr = ba3_addr;
        endcase
    end

    // The completing cycle also acts as an arbitration slot so back-to-back grants lose no cycle
    assign done  = (state_q == StData && cnt_q == CntLast) ||
                   (state_q == StWait && wr_q && cnt_q == CntLat);
    assign grant = (state_q == StIdle || done) && (downloading ? prog_req : rr_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: ;
            StWait: begin
                cnt_d = cnt_q + 5'd1;
                if (!wr_q && cnt_q == CntWaitEnd) begin
                    state_d = StData;
                end else if (done) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                cnt_d = cnt_q + 5'd1;
                if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant) begin
            state_d = StWait;
            cnt_d   = '0;
        end
    end

    // mem_dout is registered into data_read, so word i is fetched MemLat+1 cycles before LAT+i
    assign capture = state_q != StIdle && !wr_q && cnt_q >= CntWaitEnd && cnt_q <= CntCapHi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q     <= '0;
            ptr_q      <= '0;
            prog_q     <= 1'b0;
            wr_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            we_mask_q  <= '0;
            data_q     <= '0;
        end else begin
            if (grant) begin
                if (downloading) begin
                    prog_q     <= 1'b1;
                    bank_q     <= prog_ba;
                    wr_q       <= prog_we;
                    mem_addr_q <= AW'({prog_ba, prog_addr});
                    mem_din_q  <= prog_data;
                    we_mask_q  <= ~prog_mask;
                end else begin
                    prog_q     <= 1'b0;
                    bank_q     <= rr_idx;
                    ptr_q      <= rr_next;
                    wr_q       <= rr_gnt[0] & ba_wr;
                    mem_addr_q <= AW'({rr_idx, sel_addr});
                    mem_din_q  <= ba0_din;
                    we_mask_q  <= ba0_din_m;
                end
            end else if (BURST == 2 && state_q == StWait && !wr_q && cnt_q == CntFetch) begin
                mem_addr_q[0] <= ~mem_addr_q[0];
            end
            if (capture) begin
                data_q <= mem_dout;
            end
        end
    end

    assign bank_oh   = 4'b0001 << bank_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign data_read = data_q;

    always_comb begin
        ba_ack   = '0;
        ba_dst   = '0;
        ba_dok   = '0;
        ba_rdy   = '0;
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
        mem_we   = '0;
        if (state_q == StWait && cnt_q == 5'd0) begin
            if (prog_q) begin
                prog_ack = 1'b1;
            end else begin
                ba_ack = bank_oh;
            end
            if (wr_q) begin
                mem_we = we_mask_q;
            end
        end
        if (prog_q) begin
            prog_rdy = done;
        end else begin
            if (state_q == StData) begin
                ba_dok = bank_oh;
            end
            if (state_q == StData && cnt_q == CntLat) begin
                ba_dst = bank_oh;
            end
            if (done) begin
                ba_rdy = bank_oh;
            end
        end
    end

endmodule

// File: tb/tb_jtcop_sdram_resp.sv
// Directed bench for jtcop_sdram_resp with a behavioural byte-maskable word memory.
module tb_jtcop_sdram_resp;

    logic        clk;
    logic        rst_n;
    logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
    logic [3:0]  ba_rd;
    logic        ba_wr;
    logic [15:0] ba0_din;
    logic [1:0]  ba0_din_m;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;
    logic        downloading;
    logic [21:0] prog_addr;
    logic [1:0]  prog_ba;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we, prog_rd;
    logic        prog_ack, prog_rdy;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic [15:0] mem_dout;

    logic [15:0] mem [logic [23:0]];
    logic        pre_en;
    logic [23:0] pre_addr;
    logic [15:0] pre_data;

    int n_total;
    int n_bad;

    jtcop_sdram_resp #(
        .AW    (24),
        .LAT   (3),
        .BURST (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ba0_addr    (ba0_addr),
        .ba1_addr    (ba1_addr),
        .ba2_addr    (ba2_addr),
        .ba3_addr    (ba3_addr),
        .ba_rd       (ba_rd),
        .ba_wr       (ba_wr),
        .ba0_din     (ba0_din),
        .ba0_din_m   (ba0_din_m),
        .ba_ack      (ba_ack),
        .ba_dst      (ba_dst),
        .ba_dok      (ba_dok),
        .ba_rdy      (ba_rdy),
        .data_read   (data_read),
        .downloading (downloading),
        .prog_addr   (prog_addr),
        .prog_ba     (prog_ba),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_rd     (prog_rd),
        .prog_ack    (prog_ack),
        .prog_rdy    (prog_rdy),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rd_mem(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        logic [15:0] w;
        mem_dout <= rd_mem(mem_addr);
        w = rd_mem(mem_addr);
        if (mem_we[0]) w[7:0] = mem_din[7:0];
        if (mem_we[1]) w[15:8] = mem_din[15:8];
        if (mem_we != 2'b00) mem[mem_addr] = w;
        if (pre_en) mem[pre_addr] = pre_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobes(input string tag, input logic [3:0] dst, input logic [3:0] dok,
                           input logic [3:0] rdy);
        check_eq(tag, {20'h0, ba_dst, ba_dok, ba_rdy}, {20'h0, dst, dok, rdy});
    endtask

    // Waits for any ack; exp_cyc of 0 skips the latency comparison
    task automatic wait_ack(input string tag, input logic [4:0] exp, input int exp_cyc);
        int n;
        logic [4:0] got;
        n = 0;
        got = '0;
        while (got == 5'd0 && n < 40) begin
            tick();
            n++;
            got = {prog_ack, ba_ack};
        end
        check_eq(tag, {27'h0, got}, {27'h0, exp});
        if (exp_cyc > 0) check_eq({tag, "_lat"}, 32'(n), 32'(exp_cyc));
    endtask

    task automatic preload(input logic [23:0] a, input logic [15:0] d);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
        ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
        downloading = 1'b0; prog_addr = '0; prog_ba = '0; prog_data = '0;
        prog_mask = 2'b11; prog_we = 1'b0; prog_rd = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        preload(24'h800010, 16'h1234);
        preload(24'h800011, 16'h5678);
        preload(24'h000001, 16'h1111);
        preload(24'h000000, 16'h2222);
        check_eq("reset_hs", {16'h0, ba_ack, ba_dst, ba_dok, ba_rdy},
                 32'h0);
        check_eq("reset_misc", {12'h0, prog_ack, prog_rdy, mem_we, data_read}, 32'h0);
        check_eq("reset_addr", {8'h0, mem_addr}, 32'h0);
        tick();
        rst_n = 1'b1;

        // Single read, bank 2
        ba2_addr = 22'h000010;
        ba_rd = 4'b0100;
        wait_ack("rd_ack", 5'b00100, 1);
        ba_rd = 4'b0000;
        tick(); strobes("rd_c1", 4'h0, 4'h0, 4'h0);
        tick(); strobes("rd_c2", 4'h0, 4'h0, 4'h0);
        tick(); strobes("rd_c3", 4'b0100, 4'b0100, 4'h0);
        check_eq("rd_w0", {16'h0, data_read}, 32'h1234);
        tick(); strobes("rd_c4", 4'h0, 4'b0100, 4'b0100);
        check_eq("rd_w1", {16'h0, data_read}, 32'h5678);
        tick(); strobes("rd_c5", 4'h0, 4'h0, 4'h0);
        check_eq("rd_hold", {16'h0, data_read}, 32'h5678);

        // Masked write, bank 0
        ba0_addr = 22'h000020;
        ba0_din = 16'hABCD;
        ba0_din_m = 2'b01;
        ba_wr = 1'b1;
        wait_ack("wr_ack", 5'b00001, 1);
        check_eq("wr_we", {30'h0, mem_we}, 32'h1);
        check_eq("wr_addr", {8'h0, mem_addr}, 32'h000020);
        check_eq("wr_din", {16'h0, mem_din}, 32'hABCD);
        ba_wr = 1'b0;
        tick(); strobes("wr_c1", 4'h0, 4'h0, 4'h0);
        check_eq("wr_we_c1", {30'h0, mem_we}, 32'h0);
        tick(); strobes("wr_c2", 4'h0, 4'h0, 4'h0);
        tick(); strobes("wr_c3", 4'h0, 4'h0, 4'b0001);
        check_eq("wr_mem", {16'h0, rd_mem(24'h000020)}, 32'h00CD);
        tick(); strobes("wr_c4", 4'h0, 4'h0, 4'h0);

        // Read-back of the masked write
        ba_rd = 4'b0001;
        wait_ack("rb_ack", 5'b00001, 1);
        ba_rd = 4'b0000;
        tick(); tick(); tick();
        check_eq("rb_w0", {16'h0, data_read}, 32'h00CD);
        tick();
        check_eq("rb_w1", {16'h0, data_read}, 32'h0000);
        tick();

        // Round-robin with all banks held
        do_reset();
        ba_rd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack($sformatf("rr_%0d", i), 5'(4'b0001 << (i % 4)), (i == 0) ? 1 : 5);
        end
        ba_rd = 4'b0000;
        for (int i = 0; i < 6; i++) tick();

        // Download priority over a pending bank-0 read
        downloading = 1'b1;
        prog_ba = 2'd1;
        prog_addr = 22'h000100;
        prog_data = 16'h55AA;
        prog_mask = 2'b00;
        prog_we = 1'b1;
        ba0_addr = 22'h000001;
        ba_rd = 4'b0001;
        wait_ack("dl_ack", 5'b10000, 1);
        check_eq("dl_we", {30'h0, mem_we}, 32'h3);
        check_eq("dl_addr", {8'h0, mem_addr}, 32'h400100);
        check_eq("dl_din", {16'h0, mem_din}, 32'h55AA);
        prog_we = 1'b0;
        tick(); tick();
        tick();
        check_eq("dl_rdy", {31'h0, prog_rdy}, 32'h1);
        check_eq("dl_mem", {16'h0, rd_mem(24'h400100)}, 32'h55AA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("dl_block_%0d", i), {27'h0, prog_ack, ba_ack}, 32'h0);
        end
        downloading = 1'b0;
        wait_ack("dl_ba0", 5'b00001, 1);

        // Burst wrap: the same read at odd address 0x000001
        ba_rd = 4'b0000;
        check_eq("wrap_addr", {8'h0, mem_addr}, 32'h000001);
        tick(); tick(); tick();
        strobes("wrap_c3", 4'b0001, 4'b0001, 4'h0);
        check_eq("wrap_w0", {16'h0, data_read}, 32'h1111);
        tick();
        check_eq("wrap_w1", {16'h0, data_read}, 32'h2222);
        tick();

        // Reset mid-read; bank 2 joins while reset so the restart pointer decides
        ba_rd = 4'b0001;
        wait_ack("rst_ack", 5'b00001, 0);
        tick(); tick();
        rst_n = 1'b0;
        ba_rd = 4'b0101;
        #1;
        check_eq("rst_hs", {16'h0, ba_ack, ba_dst, ba_dok, ba_rdy}, 32'h0);
        check_eq("rst_misc", {12'h0, prog_ack, prog_rdy, mem_we, data_read}, 32'h0);
        check_eq("rst_addr", {8'h0, mem_addr}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        wait_ack("rst_regrant", 5'b00001, 1);
        check_eq("rst_nowr", {30'h0, mem_we}, 32'h0);
        ba_rd = 4'b0000;
        for (int i = 0; i < 6; i++) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
